shift_arbiter: RTL and testbench

Shares one 8-bit logical-shift-right datapath among NUM_REQ requesters. Each requester presents an 8-bit operand and a 3-bit shift amount over a valid/ready handshake. A round-robin arbiter grants one request per cycle. The shifted result is registered into a single-entry output buffer, tagged with the winning requester's index. The block sits between the per-lane command sources and the result consumer.

---
 rtl/shift_arb_pkg.sv | 25 ++
 rtl/shift_arbiter_if.sv | 30 +++
 rtl/shift_arbiter_rr_arbiter.sv | 56 +++++
 rtl/shift_arbiter.sv | 111 +++++++++++
 tb/tb_shift_arbiter.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/shift_arb_pkg.sv
// Shared types, widths and the shift helper for shift_arbiter.
package shift_arb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned AMT_W  = 3;

  // Output buffer occupancy.
  typedef enum logic [0:0] {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // One requester command: operand plus shift amount.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
  } shift_cmd_t;

  // Zero-fill logical shift right, result stays DATA_W bits.
  function automatic logic [DATA_W-1:0] lsr8(input logic [DATA_W-1:0] data,
                                              input logic [AMT_W-1:0]  amt);
    return data >> amt;
  endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the command lanes, shift_arbiter and the consumer.
interface shift_arbiter_if
  import shift_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*AMT_W-1:0]  req_amt;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;

  // Requester/consumer side.
  modport master (
    output req_valid, req_data, req_amt, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_amt, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/shift_arbiter_rr_arbiter.sv
// Request arbiter: scans req starting at ptr (wrapping) and grants the first set bit.
// Build option SHIFT_ARB_FIXED_PRIO_EN: scan always starts at 0 and ptr is ignored.
module rr_arbiter
  import shift_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

`ifdef SHIFT_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`else
  localparam int unsigned SUM_W = ID_W + 1;
  logic [SUM_W-1:0] sum;
`endif

  logic [ID_W-1:0] cand;
  logic            found;

  // Priority scan from the start index; grant is gated by en, index is not.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
    sum     = '0;
`endif
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      cand = ID_W'(k);
`else
      sum = {1'b0, ptr} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_REQ)) begin
        sum = sum - SUM_W'(NUM_REQ);
      end
      cand = sum[ID_W-1:0];
`endif
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (en && found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: NUM_REQ requesters share one 8-bit LSR datapath; single-entry
// registered result buffer tagged with the winner's index.
// Build option SHIFT_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic         clk,
  input  logic         rst,
  shift_arbiter_if.slave bus
);

  buf_state_e        state_q, state_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [ID_W-1:0]   ptr_c;
  logic [ID_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic              accept_c;
  logic              arb_en_c;
  logic              xfer_c;
  shift_cmd_t        sel_cmd_c;

  // Buffer can take a new result when empty or being drained this cycle.
  assign accept_c = (state_q == BUF_EMPTY) || bus.rsp_ready;
  assign arb_en_c = accept_c && !rst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_c),
    .en      (arb_en_c),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign xfer_c        = |gnt;
  assign bus.req_ready = gnt;

  // One-hot select of the granted lane's command.
  always_comb begin
    sel_cmd_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_cmd_c.data = bus.req_data[i*DATA_W +: DATA_W];
        sel_cmd_c.amt  = bus.req_amt[i*AMT_W +: AMT_W];
      end
    end
  end

`ifdef SHIFT_ARB_FIXED_PRIO_EN
  assign ptr_c = '0;
`else
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Round-robin pointer moves to the slot after the winner on each transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer_c) begin
      ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_c = ptr_q;
`endif

  // Buffer next state: load on transfer, empty on drain without refill.
  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    if (xfer_c) begin
      state_d    = BUF_FULL;
      rsp_data_d = lsr8(sel_cmd_c.data, sel_cmd_c.amt);
      rsp_id_d   = gnt_idx;
    end else if ((state_q == BUF_FULL) && bus.rsp_ready) begin
      state_d = BUF_EMPTY;
    end
  end

  // Buffer registers; reset discards any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BUF_EMPTY;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign bus.rsp_valid = (state_q == BUF_FULL);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed, table-driven bench for shift_arbiter (NUM_REQ=4, round-robin build).
module tb_shift_arbiter;
  import shift_arb_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;

  // Lane operands: lane0 B6>>3=16, lane1 F0>>4=0F, lane2 81>>1=40, lane3 FF>>7=01
  localparam logic [31:0] D_STD = {8'hFF, 8'h81, 8'hF0, 8'hB6};
  localparam logic [11:0] A_STD = {3'd7, 3'd1, 3'd4, 3'd3};

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [31:0] d;
    logic [11:0] a;
    logic        rr;
    logic [3:0]  e_rdy;
    logic        e_vld;
    logic [7:0]  e_data;
    logic [1:0]  e_id;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  shift_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus ();

  shift_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d,
                     input logic [11:0] a, input logic rr, input logic [3:0] erdy,
                     input logic evld, input logic [7:0] edata, input logic [1:0] eid);
    vecs.push_back(vec_t'{r, v, d, a, rr, erdy, evld, edata, eid});
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d,
                       input logic [11:0] a, input logic rr);
    rst           = r;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_amt   = a;
    bus.rsp_ready = rr;
  endtask

  initial begin
    logic granted;
    int   waited;

    drive(1'b1, 4'b0, 32'h0, 12'h0, 1'b0);

    //  rst  valid    data                                  amt                       rr   rdy      vld  data   id
    add(1'b1, 4'hF, D_STD, A_STD, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0); // reset
    add(1'b0, 4'h1, D_STD, A_STD, 1'b1, 4'b0001, 1'b1, 8'h16, 2'd0); // single request
    add(1'b0, 4'h1, {8'hFF, 8'h81, 8'hF0, 8'hFF}, {3'd7, 3'd1, 3'd4, 3'd0}, 1'b1, 4'b0001, 1'b1, 8'hFF, 2'd0);
    add(1'b0, 4'h1, {8'hFF, 8'h81, 8'hF0, 8'hFF}, {3'd7, 3'd1, 3'd4, 3'd7}, 1'b1, 4'b0001, 1'b1, 8'h01, 2'd0);
    add(1'b0, 4'h1, {8'hFF, 8'h81, 8'hF0, 8'h80}, {3'd7, 3'd1, 3'd4, 3'd7}, 1'b1, 4'b0001, 1'b1, 8'h01, 2'd0);
    add(1'b0, 4'h1, {8'hFF, 8'h81, 8'hF0, 8'h7F}, {3'd7, 3'd1, 3'd4, 3'd7}, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0);
    add(1'b0, 4'h0, D_STD, A_STD, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0); // drain, ptr stays 1
    add(1'b0, 4'h3, D_STD, A_STD, 1'b1, 4'b0010, 1'b1, 8'h0F, 2'd1); // ptr=1 picks lane1
    add(1'b0, 4'h1, D_STD, A_STD, 1'b1, 4'b0001, 1'b1, 8'h16, 2'd0); // FULL 16/id0
    for (int i = 0; i < 5; i++)                                      // back-pressure
      add(1'b0, 4'h2, D_STD, A_STD, 1'b0, 4'b0000, 1'b1, 8'h16, 2'd0);
    add(1'b0, 4'h2, D_STD, A_STD, 1'b1, 4'b0010, 1'b1, 8'h0F, 2'd1); // release
    add(1'b0, 4'h0, D_STD, A_STD, 1'b1, 4'b0000, 1'b0, 8'h0F, 2'd1); // drain holds data/id
    add(1'b0, 4'h4, D_STD, A_STD, 1'b1, 4'b0100, 1'b1, 8'h40, 2'd2); // FULL id2, ptr=3
    add(1'b1, 4'hF, D_STD, A_STD, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0); // reset mid-stream
    for (int i = 0; i < 2; i++) begin                                // fairness 0,1,2,3 x2
      add(1'b0, 4'hF, D_STD, A_STD, 1'b1, 4'b0001, 1'b1, 8'h16, 2'd0);
      add(1'b0, 4'hF, D_STD, A_STD, 1'b1, 4'b0010, 1'b1, 8'h0F, 2'd1);
      add(1'b0, 4'hF, D_STD, A_STD, 1'b1, 4'b0100, 1'b1, 8'h40, 2'd2);
      add(1'b0, 4'hF, D_STD, A_STD, 1'b1, 4'b1000, 1'b1, 8'h01, 2'd3);
    end
    add(1'b0, 4'h0, D_STD, A_STD, 1'b0, 4'b0000, 1'b1, 8'h01, 2'd3); // FULL hold
    add(1'b0, 4'h0, D_STD, A_STD, 1'b1, 4'b0000, 1'b0, 8'h01, 2'd3); // drain
    add(1'b0, 4'h4, D_STD, A_STD, 1'b0, 4'b0100, 1'b1, 8'h40, 2'd2); // EMPTY accepts w/o rsp_ready
    add(1'b0, 4'h5, D_STD, A_STD, 1'b0, 4'b0000, 1'b1, 8'h40, 2'd2); // stalled
    add(1'b0, 4'h5, D_STD, A_STD, 1'b1, 4'b0001, 1'b1, 8'h16, 2'd0); // ptr=3 wraps to lane0

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].a, vecs[i].rr);
      #1;
      check($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].e_vld));
      check($sformatf("v%0d rsp_data", i), 32'(bus.rsp_data), 32'(vecs[i].e_data));
      check($sformatf("v%0d rsp_id", i), 32'(bus.rsp_id), 32'(vecs[i].e_id));
    end

    // Lane3 alone after ptr=1: bounded wait for its grant, expected immediately.
    @(negedge clk);
    drive(1'b0, 4'h8, D_STD, A_STD, 1'b1);
    granted = 1'b0;
    waited  = 0;
    for (int c = 0; c < 4 && !granted; c++) begin
      #1;
      if (bus.req_ready[3]) granted = 1'b1;
      else begin
        waited++;
        @(negedge clk);
      end
    end
    check("seq lane3 granted", 32'(granted), 32'd1);
    check("seq lane3 wait cycles", 32'(waited), 32'd0);
    @(posedge clk);
    #1;
    check("seq lane3 rsp_data", 32'(bus.rsp_data), 32'h01);
    check("seq lane3 rsp_id", 32'(bus.rsp_id), 32'd3);

    // Stall lane1 three cycles, then release: accepted in the release cycle.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b0, 4'h2, D_STD, A_STD, 1'b0);
      #1;
      check($sformatf("seq stall%0d req_ready", c), 32'(bus.req_ready), 32'd0);
      check($sformatf("seq stall%0d rsp_data", c), 32'(bus.rsp_data), 32'h01);
      check($sformatf("seq stall%0d rsp_valid", c), 32'(bus.rsp_valid), 32'd1);
    end
    @(negedge clk);
    drive(1'b0, 4'h2, D_STD, A_STD, 1'b1);
    #1;
    check("seq release req_ready", 32'(bus.req_ready), 32'b0010);
    @(posedge clk);
    #1;
    check("seq release rsp_data", 32'(bus.rsp_data), 32'h0F);
    check("seq release rsp_id", 32'(bus.rsp_id), 32'd1);

    @(negedge clk);
    drive(1'b0, 4'h0, D_STD, A_STD, 1'b1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
